ins_decode_seq: RTL and testbench

INS_DECODE_SEQ -- requirements
Module: ins_decode_seq

---
 rtl/ins_pkg.sv | 47 ++++
 rtl/ins_decode_comb.sv | 51 +++++
 rtl/ins_decode_seq.sv | 98 +++++++++
 tb/tb_ins_decode_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_pkg.sv
// Shared instruction-set constants: opcodes, one-hot op bit positions and T-state lengths.
// Reusable by any controller that consumes the decoded one-hot op vector.
package ins_pkg;

  typedef enum logic [1:0] {StIdle, StExec, StHalt} state_e;

  localparam logic [3:0] OpcMove  = 4'b1100;
  localparam logic [3:0] OpcAdd   = 4'b1001;
  localparam logic [3:0] OpcSub   = 4'b0110;
  localparam logic [3:0] OpcAnd   = 4'b1011;
  localparam logic [3:0] OpcNot   = 4'b0101;
  localparam logic [3:0] OpcShift = 4'b1010;
  localparam logic [3:0] OpcJump  = 4'b0011;
  localparam logic [3:0] OpcIn    = 4'b0010;
  localparam logic [3:0] OpcOut   = 4'b0100;
  localparam logic [3:0] OpcNop   = 4'b0111;
  localparam logic [3:0] OpcHalt  = 4'b1000;

  localparam int unsigned NumOps  = 16;
  localparam int unsigned BitMova = 0;
  localparam int unsigned BitMovb = 1;
  localparam int unsigned BitMovc = 2;
  localparam int unsigned BitAdd  = 3;
  localparam int unsigned BitSub  = 4;
  localparam int unsigned BitAnd1 = 5;
  localparam int unsigned BitNot1 = 6;
  localparam int unsigned BitRsr  = 7;
  localparam int unsigned BitRsl  = 8;
  localparam int unsigned BitJmp  = 9;
  localparam int unsigned BitJz   = 10;
  localparam int unsigned BitJc   = 11;
  localparam int unsigned BitIn1  = 12;
  localparam int unsigned BitOut1 = 13;
  localparam int unsigned BitNop  = 14;
  localparam int unsigned BitHalt = 15;

  // ALU, shift and branch ops (bits 3..11) take two T-states.
  localparam logic [NumOps-1:0] Len2Mask = 16'h0FF8;

  // An all-zero op (illegal instruction) is a single T-state.
  function automatic int unsigned ins_len(logic [NumOps-1:0] op);
    if (op[BitIn1] || op[BitOut1]) return 3;
    if (|(op & Len2Mask)) return 2;
    return 1;
  endfunction

endpackage

// File: rtl/ins_decode_comb.sv
// Combinational opcode decode: instruction word to one-hot op vector plus illegal flag.
module ins_decode_comb
  import ins_pkg::*;
#(
  parameter int unsigned IR_W = 8
) (
  input  logic [IR_W-1:0]   ir,
  output logic [NumOps-1:0] op,
  output logic              illegal
);

  logic [3:0] opcode;
  logic [3:0] sub;

  assign opcode = ir[IR_W-1 -: 4];
  assign sub    = ir[3:0];

  always_comb begin
    op      = '0;
    illegal = 1'b0;
    unique case (opcode)
      OpcMove: begin
        if (sub[3:2] == 2'b11)      op[BitMovb] = 1'b1;
        else if (sub[1:0] == 2'b11) op[BitMovc] = 1'b1;
        else                        op[BitMova] = 1'b1;
      end
      OpcAdd:   op[BitAdd]  = 1'b1;
      OpcSub:   op[BitSub]  = 1'b1;
      OpcAnd:   op[BitAnd1] = 1'b1;
      OpcNot:   op[BitNot1] = 1'b1;
      OpcShift: begin
        if (sub[1:0] == 2'b11) op[BitRsl] = 1'b1;
        else                   op[BitRsr] = 1'b1;
      end
      OpcJump: begin
        unique case (sub[1:0])
          2'b00:   op[BitJmp] = 1'b1;
          2'b01:   op[BitJz]  = 1'b1;
          2'b10:   op[BitJc]  = 1'b1;
          default: illegal    = 1'b1;
        endcase
      end
      OpcIn:   op[BitIn1]  = 1'b1;
      OpcOut:  op[BitOut1] = 1'b1;
      OpcNop:  op[BitNop]  = 1'b1;
      OpcHalt: op[BitHalt] = 1'b1;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/ins_decode_seq.sv
// Instruction sequencer: accepts an instruction, holds its one-hot op and steps T-states
// until the instruction's length is reached; halt parks the sequencer until reset.
module ins_decode_seq
  import ins_pkg::*;
#(
  parameter int unsigned IR_W = 8,
  parameter int unsigned T_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IR_W-1:0]   ir,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic              zf,
  input  logic              cf,
  output logic [NumOps-1:0] op,
  output logic [T_W-1:0]    t_state,
  output logic              ins_done,
  output logic              jump_taken,
  output logic              illegal,
  output logic              halted
);

  state_e             state_q;
  logic [NumOps-1:0]  op_q;
  logic               illegal_q;
  logic [T_W-1:0]     t_q;
  logic               halted_q;

  logic [NumOps-1:0]  dec_op;
  logic               dec_illegal;
  logic [T_W-1:0]     last_t;
  logic               last;
  logic               fire;

  ins_decode_comb #(
    .IR_W (IR_W)
  ) u_decode (
    .ir      (ir),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign last_t = T_W'(ins_len(op_q) - 32'd1);
  assign last   = (state_q == StExec) && (t_q == last_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      illegal_q <= 1'b0;
      t_q       <= '0;
      halted_q  <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          if (ir_valid) begin
            op_q      <= dec_op;
            illegal_q <= dec_illegal;
            t_q       <= '0;
            state_q   <= StExec;
          end
        end
        StExec: begin
          if (last) begin
            t_q       <= '0;
            illegal_q <= 1'b0;
            // Halt keeps its op bit visible while parked.
            if (op_q[BitHalt]) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              op_q    <= '0;
            end
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pulses are gated by rst so an aborted instruction never reports completion.
  assign fire       = en & ~rst & last;
  assign ins_done   = fire;
  assign illegal    = fire & illegal_q;
  assign jump_taken = fire & (op_q[BitJmp] | (op_q[BitJz] & zf) | (op_q[BitJc] & cf));

  assign ir_ready = en & (state_q == StIdle);
  assign op       = op_q;
  assign t_state  = t_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_ins_decode_seq.sv
// Directed bench for ins_decode_seq; completed instructions are checked against a scoreboard.
module tb_ins_decode_seq;

  logic        clk = 1'b0;
  logic        rst, en, ir_valid, zf, cf;
  logic [7:0]  ir;
  logic        ir_ready, ins_done, jump_taken, illegal, halted;
  logic [15:0] op;
  logic [1:0]  t_state;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] op;
    logic        ill;
    logic        jmp;
  } exp_t;

  exp_t sb[$];

  ins_decode_seq #(
    .IR_W (8),
    .T_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .zf         (zf),
    .cf         (cf),
    .op         (op),
    .t_state    (t_state),
    .ins_done   (ins_done),
    .jump_taken (jump_taken),
    .illegal    (illegal),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled at negedge by the monitor; main flow checks and drives just after.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] eop, input logic eill, input logic ejmp);
    exp_t e;
    e.op  = eop;
    e.ill = eill;
    e.jmp = ejmp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ins_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ins_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_op", 32'(op), 32'(e.op));
        check("sb_illegal", 32'(illegal), 32'(e.ill));
        check("sb_jump", 32'(jump_taken), 32'(e.jmp));
      end
    end else if ((illegal | jump_taken) !== 1'b0) begin
      check("pulse_without_done", 32'(illegal | jump_taken), 32'd0);
    end
  end

  task automatic run_ins(input logic [7:0] i, input logic [15:0] eop, input logic eill,
                         input logic ejmp, input int elen);
    int n;
    check($sformatf("ready_%02h", i), 32'(ir_ready), 32'd1);
    ir       = i;
    ir_valid = 1'b1;
    push(eop, eill, ejmp);
    cyc();
    ir_valid = 1'b0;
    check($sformatf("op_%02h", i), 32'(op), 32'(eop));
    n = 1;
    while (ins_done !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    check($sformatf("len_%02h", i), 32'(n), 32'(elen));
    cyc();
    check($sformatf("ready_after_%02h", i), 32'(ir_ready), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    ir_valid = 1'b0;
    ir       = 8'h00;
    zf       = 1'b0;
    cf       = 1'b0;
    cyc();
    cyc();
    check("rst_op", 32'(op), 32'd0);
    check("rst_t", 32'(t_state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_done", 32'(ins_done), 32'd0);
    rst = 1'b0;
    cyc();
    check("idle_ready", 32'(ir_ready), 32'd1);

    // add: two T-states
    ir = 8'h90;
    ir_valid = 1'b1;
    push(16'h0008, 1'b0, 1'b0);
    cyc();
    ir_valid = 1'b0;
    check("add_op_t0", 32'(op), 32'h0008);
    check("add_t0", 32'(t_state), 32'd0);
    check("add_done_t0", 32'(ins_done), 32'd0);
    check("add_ready_exec", 32'(ir_ready), 32'd0);
    cyc();
    check("add_op_t1", 32'(op), 32'h0008);
    check("add_t1", 32'(t_state), 32'd1);
    check("add_done_t1", 32'(ins_done), 32'd1);
    cyc();
    check("add_ready_after", 32'(ir_ready), 32'd1);
    check("add_op_idle", 32'(op), 32'd0);

    // jz taken / not taken; flag applied in the last T-state
    zf = 1'b0;
    ir = 8'h31;
    ir_valid = 1'b1;
    push(16'h0400, 1'b0, 1'b1);
    cyc();
    ir_valid = 1'b0;
    zf = 1'b1;
    cyc();
    check("jz1_jump", 32'(jump_taken), 32'd1);
    cyc();
    zf = 1'b1;
    ir_valid = 1'b1;
    push(16'h0400, 1'b0, 1'b0);
    cyc();
    ir_valid = 1'b0;
    zf = 1'b0;
    cyc();
    check("jz0_jump", 32'(jump_taken), 32'd0);
    check("jz0_done", 32'(ins_done), 32'd1);
    cyc();

    // in1 with a 3-cycle stall in the middle
    ir = 8'h20;
    ir_valid = 1'b1;
    push(16'h1000, 1'b0, 1'b0);
    cyc();
    ir_valid = 1'b0;
    check("in1_t0", 32'(t_state), 32'd0);
    cyc();
    check("in1_t1", 32'(t_state), 32'd1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("in1_stall_t", 32'(t_state), 32'd1);
      check("in1_stall_done", 32'(ins_done), 32'd0);
      check("in1_stall_ready", 32'(ir_ready), 32'd0);
      check("in1_stall_op", 32'(op), 32'h1000);
    end
    en = 1'b1;
    cyc();
    check("in1_t2", 32'(t_state), 32'd2);
    check("in1_done_6th", 32'(ins_done), 32'd1);
    cyc();

    // illegal opcodes
    ir = 8'hF0;
    ir_valid = 1'b1;
    push(16'h0000, 1'b1, 1'b0);
    cyc();
    ir_valid = 1'b0;
    check("ill_f0_flag", 32'(illegal), 32'd1);
    check("ill_f0_done", 32'(ins_done), 32'd1);
    check("ill_f0_op", 32'(op), 32'd0);
    cyc();
    check("ill_f0_ready", 32'(ir_ready), 32'd1);
    ir = 8'h33;
    ir_valid = 1'b1;
    push(16'h0000, 1'b1, 1'b0);
    cyc();
    ir_valid = 1'b0;
    check("ill_33_flag", 32'(illegal), 32'd1);
    check("ill_33_done", 32'(ins_done), 32'd1);
    cyc();
    check("ill_33_ready", 32'(ir_ready), 32'd1);

    // decode table sweep
    cf = 1'b1;
    zf = 1'b0;
    run_ins(8'hC0, 16'h0001, 1'b0, 1'b0, 1);
    run_ins(8'hCC, 16'h0002, 1'b0, 1'b0, 1);
    run_ins(8'hC3, 16'h0004, 1'b0, 1'b0, 1);
    run_ins(8'h60, 16'h0010, 1'b0, 1'b0, 2);
    run_ins(8'hB0, 16'h0020, 1'b0, 1'b0, 2);
    run_ins(8'h50, 16'h0040, 1'b0, 1'b0, 2);
    run_ins(8'hA0, 16'h0080, 1'b0, 1'b0, 2);
    run_ins(8'hA3, 16'h0100, 1'b0, 1'b0, 2);
    run_ins(8'h30, 16'h0200, 1'b0, 1'b1, 2);
    run_ins(8'h32, 16'h0800, 1'b0, 1'b1, 2);
    run_ins(8'h40, 16'h2000, 1'b0, 1'b0, 3);
    run_ins(8'h70, 16'h4000, 1'b0, 1'b0, 1);
    run_ins(8'h31, 16'h0400, 1'b0, 1'b0, 2);
    run_ins(8'hE0, 16'h0000, 1'b1, 1'b0, 1);
    cf = 1'b0;

    // reset aborts out1 at t_state 1
    ir = 8'h40;
    ir_valid = 1'b1;
    cyc();
    ir_valid = 1'b0;
    cyc();
    check("out1_t1", 32'(t_state), 32'd1);
    rst = 1'b1;
    cyc();
    check("abort_op", 32'(op), 32'd0);
    check("abort_t", 32'(t_state), 32'd0);
    check("abort_done", 32'(ins_done), 32'd0);
    rst = 1'b0;
    cyc();
    cyc();
    check("abort_ready", 32'(ir_ready), 32'd1);

    // halt parks until reset
    ir = 8'h80;
    ir_valid = 1'b1;
    push(16'h8000, 1'b0, 1'b0);
    cyc();
    ir = 8'h90;
    check("halt_done", 32'(ins_done), 32'd1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("halt_level", 32'(halted), 32'd1);
      check("halt_ready", 32'(ir_ready), 32'd0);
      check("halt_op", 32'(op), 32'h8000);
    end
    ir_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("halt_rst_halted", 32'(halted), 32'd0);
    check("halt_rst_op", 32'(op), 32'd0);
    cyc();
    check("halt_rst_ready", 32'(ir_ready), 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
